// File: rtl/sct_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sct_seq_ctrl
// Purpose  : Sequential counter controller for the SCT sequencing path.
//            Holds the count/reload registers, accepts LOAD/START/STOP
//            commands over valid/ready, counts on an enable tick and
//            reports every terminal-count wrap as a sequence-numbered event
//            through a 2-entry first-word-fall-through buffer. Events that
//            arrive while the buffer is full (and not draining) are dropped,
//            flagged in a sticky overrun bit and counted (saturating).
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            cmd_valid/cmd_ready - command handshake
//            cmd_op, cmd_data    - 00 NOP, 01 LOAD, 10 START, 11 STOP; data
//            cnt_en              - count-enable tick
//            cnt_q, busy         - current count, high while running
//            evt_valid/evt_ready - event handshake, evt_seq = head sequence
//            overrun, drop_cnt   - sticky drop flag, saturating drop count
// Config   : define SCT_SEQ_PRESCALE_EN to divide cnt_en by PRESCALE.
// Revision : 1.0 - initial release
// ============================================================================
module sct_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int SEQ_W    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt_q,
  output logic             busy,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [SEQ_W-1:0] evt_seq,
  output logic             overrun,
  output logic [3:0]       drop_cnt
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reject nonsensical parameterisations at elaboration time.
  if (CNT_W < 2 || SEQ_W < 1 || PRESCALE < 1) begin : g_bad_param
    $error("sct_seq_ctrl: illegal parameter value");
  end

  state_t           state;
  logic [CNT_W-1:0] reload;
  logic [SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] seq_next;
  logic [SEQ_W-1:0] fifo0;   // head entry
  logic [SEQ_W-1:0] fifo1;   // second entry
  logic [1:0]       fifo_cnt;

  logic cmd_fire;
  logic is_load;
  logic is_start;
  logic is_stop;
  logic tick;
  logic do_count;
  logic push;
  logic pop;
  logic drop;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign is_load  = cmd_fire & (cmd_op == OP_LOAD);
  assign is_start = cmd_fire & (cmd_op == OP_START);
  assign is_stop  = cmd_fire & (cmd_op == OP_STOP);

`ifdef SCT_SEQ_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  // Tick on the PRESCALE-th enable pulse seen while running.
  assign tick = cnt_en & (state == ST_RUN) & (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (is_load | is_start | is_stop) begin
      ps_cnt <= '0;
    end else if ((state == ST_RUN) && cnt_en) begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end
  end
`else
  assign tick = cnt_en;
`endif

  // LOAD and STOP both pre-empt a same-cycle tick; a START from IDLE only
  // takes effect at this edge, so the tick is ignored because state is IDLE.
  assign do_count = (state == ST_RUN) & tick & ~is_load & ~is_stop;
  assign push     = do_count & (&cnt_q);
  assign seq_next = seq + 1'b1;
  assign pop      = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot, so only a stalled full buffer drops.
  assign drop     = push & (fifo_cnt == 2'd2) & ~pop;

  assign busy      = (state == ST_RUN);
  assign evt_valid = (fifo_cnt != 2'd0);
  assign evt_seq   = fifo0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
    end
  end

  // Control FSM with count, reload and sequence registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt_q  <= '0;
      reload <= '0;
      seq    <= '0;
    end else begin
      if (is_load) begin
        reload <= cmd_data;
        cnt_q  <= cmd_data;
      end else if (do_count) begin
        if (&cnt_q) begin
          cnt_q <= reload;
          seq   <= seq_next;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      case (state)
        ST_IDLE: if (is_start) state <= ST_RUN;
        ST_RUN:  if (is_stop)  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry FWFT event buffer; entry 0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo0    <= '0;
      fifo1    <= '0;
      fifo_cnt <= 2'd0;
    end else begin
      case (fifo_cnt)
        2'd0: begin
          if (push) begin
            fifo0    <= seq_next;
            fifo_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            fifo0 <= seq_next;
          end else if (push) begin
            fifo1    <= seq_next;
            fifo_cnt <= 2'd2;
          end else if (pop) begin
            fifo_cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            fifo0 <= fifo1;
            if (push) begin
              fifo1 <= seq_next;
            end else begin
              fifo_cnt <= 2'd1;
            end
          end
        end
        default: fifo_cnt <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= 4'd0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_cnt != 4'hF) begin
        drop_cnt <= drop_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
